// File: rtl/core_pkg.sv
// Shared definitions for the fetch side of the pipelined modified-MIPS core.
//   IMEM_BYTES        instruction memory size in bytes
//   RESET_PC_DEFAULT  byte address of the first fetch after reset
//   NOP_WORD          encoding used for IF/ID bubbles
//   fetch_state_e     fetch FSM states {FS_BOOT, FS_RUN, FS_HALT}
//   pc_is_bad()       misaligned or beyond the last full word of memory
package core_pkg;

    localparam int unsigned IMEM_BYTES       = 16384;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd100;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    // The last legal word starts at mem_bytes-4; anything above it, or not
    // word aligned, cannot be fetched.
    function automatic logic pc_is_bad(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection and fetch fault detection.
//   clk, rst_n        clock, asynchronous active-low reset
//   run_i             fetch FSM is in FS_RUN (PC only moves while running)
//   stall_i           hold PC (load-use hazard)
//   branch_taken_i    redirect to branch_target_i (wins over stall)
//   branch_target_i   byte address of the redirect
//   pc_o              current PC
//   pc_plus4_o        PC + 4 (wraps modulo 2^32)
//   fault_o           current PC would be fetched this edge but is illegal
module fetch_pc_reg
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_BYTES = IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fault_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;

    // A bad PC only matters on an edge that would actually latch its word:
    // a redirect discards it and a stall defers the decision.
    assign fault_o = run_i && !branch_taken_i && !stall_i
                     && pc_is_bad(pc_q, 32'(MEM_BYTES));

    always_comb begin
        pc_d = pc_q;
        if (run_i) begin
            if (branch_taken_i) begin
                pc_d = branch_target_i;
            end else if (!stall_i && !fault_o) begin
                pc_d = pc_plus4_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: presents the PC to a combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold PC and IF/ID (load-use hazard)
//   branch_taken        redirect from ID this cycle; flushes IF/ID
//   branch_target       byte address fetched after a redirect
//   imem_pc             byte address to instruction memory (= PC)
//   imem_instruction    word returned for imem_pc
//   if_id_instruction   latched instruction (0 = NOP bubble)
//   if_id_pc_plus4      PC+4 of the latched instruction
//   if_id_valid         IF/ID holds a real fetch
//   fetch_fault         sticky illegal-PC indication; fetch halts until reset
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_BYTES = IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  pc_plus4;
    logic         pc_fault;

    fetch_pc_reg #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc (
        .clk             (clk),
        .rst_n           (rst_n),
        .run_i           (state_q == FS_RUN),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_o            (imem_pc),
        .pc_plus4_o      (pc_plus4),
        .fault_o         (pc_fault)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        unique case (state_q)
            // One idle edge after reset so the first memory read settles.
            FS_BOOT: state_d = FS_RUN;
            FS_RUN: begin
                if (branch_taken) begin
                    // The word at imem_pc is wrong-path; drop it.
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // hold everything
                end else if (pc_fault) begin
                    fault_d = 1'b1;
                    state_d = FS_HALT;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_instruction;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            FS_HALT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: state_d = FS_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_BOOT;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc4_q;
    assign if_id_valid       = valid_q;
    assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a combinational instruction memory model,
// vector tables of {stall, branch, target} with the expected post-edge outputs,
// pushed to a scoreboard queue when driven and popped after the edge.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_pc           (imem_pc),
        .imem_instruction  (imem_instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_fault       (fetch_fault)
    );

    // Instruction memory responder: program words from 100 upward follow
    // 48080000, 48090004, 480a0008, ...; a few fixed words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'd100 && a < 32'd700 && a[1:0] == 2'b00)
            return 32'h4808_0000 + ((a - 32'd100) >> 2) * 32'h0001_0004;
        case (a)
            32'd700:   return 32'h2413_000f;
            32'd704:   return 32'h2414_0010;
            32'd16376: return 32'h8c01_1234;
            32'd16380: return 32'hac01_5678;
            default:   return 32'hdead_beef;
        endcase
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t seq_a[$];
    vec_t seq_b[$];
    vec_t sb[$];

    function automatic vec_t mkv(input logic s, input logic b, input logic [31:0] t,
                                 input logic [31:0] pc, input logic [31:0] ins,
                                 input logic [31:0] p4, input logic v, input logic f);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t;
        r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.e_valid = v; r.e_fault = f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge (or just after reset release): drive, push the
    // expectation, let one rising edge pass, then pop and compare.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        stall = v.stall;
        branch_taken = v.br;
        branch_target = v.tgt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: vector %0d had no expectation", idx);
        end else begin
            e = sb.pop_front();
            tests--;
            chk($sformatf("v%0d imem_pc", idx), imem_pc, e.e_pc);
            chk($sformatf("v%0d instr", idx), if_id_instruction, e.e_instr);
            chk($sformatf("v%0d pc_plus4", idx), if_id_pc_plus4, e.e_pc4);
            chk($sformatf("v%0d valid", idx), {31'd0, if_id_valid}, {31'd0, e.e_valid});
            chk($sformatf("v%0d fault", idx), {31'd0, fetch_fault}, {31'd0, e.e_fault});
            $display("[TB] v%0d stall=%0b br=%0b tgt=%0d -> pc=%0d instr=%08h pc4=%0d valid=%0b fault=%0b",
                     idx, v.stall, v.br, v.tgt, imem_pc, if_id_instruction,
                     if_id_pc_plus4, if_id_valid, fetch_fault);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " imem_pc"}, imem_pc, 32'd100);
        chk({tag, " instr"}, if_id_instruction, 32'd0);
        chk({tag, " pc_plus4"}, if_id_pc_plus4, 32'd0);
        chk({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, " fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        // Boot, sequential fetch, stall, branch+stall, bad branch target, halt.
        seq_a.push_back(mkv(0, 0, 0,   100, 32'h0,         0,   0, 0));
        seq_a.push_back(mkv(0, 0, 0,   104, 32'h4808_0000, 104, 1, 0));
        seq_a.push_back(mkv(0, 0, 0,   108, 32'h4809_0004, 108, 1, 0));
        seq_a.push_back(mkv(1, 0, 0,   108, 32'h4809_0004, 108, 1, 0));
        seq_a.push_back(mkv(1, 0, 0,   108, 32'h4809_0004, 108, 1, 0));
        seq_a.push_back(mkv(0, 0, 0,   112, 32'h480a_0008, 112, 1, 0));
        seq_a.push_back(mkv(1, 1, 700, 700, 32'h0,         112, 0, 0));
        seq_a.push_back(mkv(0, 0, 0,   704, 32'h2413_000f, 704, 1, 0));
        seq_a.push_back(mkv(0, 1, 702, 702, 32'h0,         704, 0, 0));
        seq_a.push_back(mkv(0, 0, 0,   702, 32'h0,         704, 0, 1));
        seq_a.push_back(mkv(1, 1, 100, 702, 32'h0,         704, 0, 1));
        seq_a.push_back(mkv(0, 1, 200, 702, 32'h0,         704, 0, 1));
        seq_a.push_back(mkv(0, 0, 0,   702, 32'h0,         704, 0, 1));

        // After a mid-run reset: boot again, then run off the end of memory.
        seq_b.push_back(mkv(0, 0, 0,     100,   32'h0,         0,     0, 0));
        seq_b.push_back(mkv(0, 0, 0,     104,   32'h4808_0000, 104,   1, 0));
        seq_b.push_back(mkv(0, 1, 16376, 16376, 32'h0,         104,   0, 0));
        seq_b.push_back(mkv(0, 0, 0,     16380, 32'h8c01_1234, 16380, 1, 0));
        seq_b.push_back(mkv(0, 0, 0,     16384, 32'hac01_5678, 16384, 1, 0));
        seq_b.push_back(mkv(0, 0, 0,     16384, 32'h0,         16384, 0, 1));
        seq_b.push_back(mkv(1, 0, 0,     16384, 32'h0,         16384, 0, 1));

        // Reset held across edges: state must stay at reset values.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < seq_a.size(); i++) step(seq_a[i], i);

        // Asynchronous reset between edges while halted.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < seq_b.size(); i++) step(seq_b[i], 100 + i);

        // Async reset mid-run (not halted): seed a few fetches first.
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset_after_fault");
        @(negedge clk);
        rst_n = 1'b1;
        step(seq_b[0], 200);
        step(seq_b[1], 201);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        step(seq_b[0], 202);
        step(seq_b[1], 203);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
